// File: rtl/pq_pkg.sv
// Shared width helpers and default sizes for the power-quality datapath.
// Keeps squarer, accumulator and downstream RMS logic agreeing on bit widths.
package pq_pkg;

   localparam int DEF_DATA_W   = 24;
   localparam int DEF_WIN_LOG2 = 8;

   // A DATA_W sign-magnitude sample has DATA_W-1 magnitude bits, so its square needs twice that.
   function automatic int sqWidth(input int dataW);
      return 2 * (dataW - 1);
   endfunction

   function automatic int accWidth(input int dataW, input int winLog2);
      return sqWidth(dataW) + winLog2;
   endfunction

   localparam int SQ_W  = sqWidth(DEF_DATA_W);
   localparam int ACC_W = accWidth(DEF_DATA_W, DEF_WIN_LOG2);

endpackage

// File: rtl/sm_square.sv
// Two-stage registered sign-magnitude squarer with valid pipeline and flush.
// Also forwards the stage-1 magnitude aligned with its square for peak tracking.
module sm_square
   import pq_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   input  logic                        in_valid,
   input  logic [DATA_W-1:0]           in_data,
   output logic                        out_valid,
   output logic [sqWidth(DATA_W)-1:0]  out_sq,
   output logic [DATA_W-2:0]           out_mag
);

   localparam int MAG_W = DATA_W - 1;
   localparam int SQ_LW = sqWidth(DATA_W);

   logic             r_v1;
   logic [MAG_W-1:0] r_mag1;
   logic             r_v2;
   logic [SQ_LW-1:0] r_sq;
   logic [MAG_W-1:0] r_mag2;

   logic [SQ_LW-1:0] w_magExt;
   logic             w_unusedSign;

   assign w_magExt     = {{MAG_W{1'b0}}, r_mag1};
   assign w_unusedSign = in_data[DATA_W-1];

   // A sample arriving with flush is kept as the first of the new window;
   // only the sample already in stage 1 is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_v1   <= 1'b0;
         r_mag1 <= '0;
         r_v2   <= 1'b0;
         r_sq   <= '0;
         r_mag2 <= '0;
      end else begin
         r_v1   <= in_valid;
         r_mag1 <= in_data[DATA_W-2:0];
         r_v2   <= r_v1 & ~flush;
         r_sq   <= w_magExt * w_magExt;
         r_mag2 <= r_mag1;
      end
   end

   assign out_valid = r_v2;
   assign out_sq    = r_sq;
   assign out_mag   = r_mag2;

endmodule

// File: rtl/mean_square_window.sv
// Windowed sum-of-squares / mean-square over 2^WIN_LOG2 samples.
// Optional peak magnitude tracker enabled by defining PEAK_DETECT_EN.
module mean_square_window
   import pq_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int WIN_LOG2 = DEF_WIN_LOG2
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   in_valid,
   input  logic [DATA_W-1:0]                      in_data,
   input  logic                                   win_clr,
   output logic                                   sq_valid,
   output logic [sqWidth(DATA_W)-1:0]             sq_out,
   output logic                                   win_valid,
   output logic [accWidth(DATA_W, WIN_LOG2)-1:0]  win_sum,
   output logic [sqWidth(DATA_W)-1:0]             win_mean,
   output logic [DATA_W-2:0]                      peak_out
);

   localparam int MAG_W = DATA_W - 1;
   localparam int SQ_LW = sqWidth(DATA_W);
   localparam int ACC_LW = accWidth(DATA_W, WIN_LOG2);

   logic              w_sqValid;
   logic [SQ_LW-1:0]  w_sq;
   logic [MAG_W-1:0]  w_mag;
   logic [ACC_LW-1:0] w_sumNext;
   logic              w_last;

   logic [ACC_LW-1:0]   r_acc;
   logic [WIN_LOG2-1:0] r_cnt;
   logic                r_winValid;
   logic [ACC_LW-1:0]   r_winSum;
   logic [SQ_LW-1:0]    r_winMean;

   sm_square #(
      .DATA_W (DATA_W)
   ) u_square (
      .clk       (clk),
      .rst       (rst),
      .flush     (win_clr),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .out_valid (w_sqValid),
      .out_sq    (w_sq),
      .out_mag   (w_mag)
   );

   assign w_sumNext = r_acc + {{WIN_LOG2{1'b0}}, w_sq};
   assign w_last    = (r_cnt == {WIN_LOG2{1'b1}});

   // Clear beats a completing square; the final square folds straight into the result
   // so the next window starts from zero with no dead cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc      <= '0;
         r_cnt      <= '0;
         r_winValid <= 1'b0;
         r_winSum   <= '0;
         r_winMean  <= '0;
      end else begin
         r_winValid <= 1'b0;
         if (win_clr) begin
            r_acc <= '0;
            r_cnt <= '0;
         end else if (w_sqValid) begin
            if (w_last) begin
               r_winSum   <= w_sumNext;
               r_winMean  <= w_sumNext[ACC_LW-1:WIN_LOG2];
               r_winValid <= 1'b1;
               r_acc      <= '0;
               r_cnt      <= '0;
            end else begin
               r_acc <= w_sumNext;
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

`ifdef PEAK_DETECT_EN
   logic [MAG_W-1:0] r_peak;
   logic [MAG_W-1:0] r_peakOut;
   logic [MAG_W-1:0] w_peakNext;

   assign w_peakNext = (w_mag > r_peak) ? w_mag : r_peak;

   // Running maximum follows the accumulator exactly, including its clear rules.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_peak    <= '0;
         r_peakOut <= '0;
      end else if (win_clr) begin
         r_peak <= '0;
      end else if (w_sqValid) begin
         if (w_last) begin
            r_peakOut <= w_peakNext;
            r_peak    <= '0;
         end else begin
            r_peak <= w_peakNext;
         end
      end
   end

   assign peak_out = r_peakOut;
`else
   logic w_unusedMag;

   assign w_unusedMag = ^w_mag;
   assign peak_out    = '0;
`endif

   assign sq_valid  = w_sqValid;
   assign sq_out    = w_sq;
   assign win_valid = r_winValid;
   assign win_sum   = r_winSum;
   assign win_mean  = r_winMean;

endmodule

// File: tb/tb_mean_square_window.sv
// Directed bench for mean_square_window with DATA_W=24, WIN_LOG2=2.
// Peak expectations follow whether PEAK_DETECT_EN is defined.
module tb_mean_square_window;

   localparam int DATA_W   = 24;
   localparam int WIN_LOG2 = 2;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [23:0] in_data;
   logic        win_clr;
   logic        sq_valid;
   logic [45:0] sq_out;
   logic        win_valid;
   logic [47:0] win_sum;
   logic [45:0] win_mean;
   logic [22:0] peak_out;

   int checks;
   int failures;

   int   pulseCount;
   int   widePulses;
   logic prevWin;
   logic [47:0] pulseExpSum;
   logic [45:0] pulseExpMean;
   logic [22:0] pulseExpPeak;

   typedef struct {
      logic        v;
      logic [23:0] d;
      logic        clr;
      logic        expSqV;
      logic [45:0] expSq;
      logic        expWinV;
      logic [47:0] expSum;
      logic [45:0] expMean;
      logic [22:0] expPeak;
   } vec_t;

   vec_t tbl [14];

   mean_square_window #(
      .DATA_W   (DATA_W),
      .WIN_LOG2 (WIN_LOG2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .win_clr   (win_clr),
      .sq_valid  (sq_valid),
      .sq_out    (sq_out),
      .win_valid (win_valid),
      .win_sum   (win_sum),
      .win_mean  (win_mean),
      .peak_out  (peak_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [22:0] peakExp(input logic [22:0] p);
`ifdef PEAK_DETECT_EN
      return p;
`else
      return 23'd0 & p;
`endif
   endfunction

   function automatic vec_t mkVec(input logic v, input logic [23:0] d, input logic clr,
                                  input logic sqV, input logic [45:0] sq, input logic wv,
                                  input logic [47:0] sum, input logic [45:0] mean,
                                  input logic [22:0] peak);
      vec_t r;
      r.v = v; r.d = d; r.clr = clr;
      r.expSqV = sqV; r.expSq = sq; r.expWinV = wv;
      r.expSum = sum; r.expMean = mean; r.expPeak = peak;
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, then observe #1 after the rising edge.
   task automatic applyStimulus(input logic v, input logic [23:0] d, input logic clr, input logic r);
      @(negedge clk);
      in_valid = v;
      in_data  = d;
      win_clr  = clr;
      rst      = r;
      @(posedge clk);
      #1;
      if (win_valid) begin
         pulseCount++;
         if (prevWin) widePulses++;
         checkOutput("pulseSum", 64'(win_sum), 64'(pulseExpSum));
         checkOutput("pulseMean", 64'(win_mean), 64'(pulseExpMean));
         checkOutput("pulsePeak", 64'(peak_out), 64'(peakExp(pulseExpPeak)));
      end
      prevWin = win_valid;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 24'd0, 1'b0, 1'b0);
   endtask

   initial begin
      checks = 0; failures = 0;
      pulseCount = 0; widePulses = 0; prevWin = 1'b0;
      pulseExpSum = '0; pulseExpMean = '0; pulseExpPeak = '0;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; win_clr = 1'b0;

      tbl[0]  = mkVec(1, 24'd3,       0, 0, 46'd0,  0, 48'd0, 46'd0, 23'd0);
      tbl[1]  = mkVec(1, 24'h800004,  0, 1, 46'd9,  0, 48'd0, 46'd0, 23'd0);
      tbl[2]  = mkVec(1, 24'd5,       0, 1, 46'd16, 0, 48'd0, 46'd0, 23'd0);
      tbl[3]  = mkVec(1, 24'd0,       0, 1, 46'd25, 0, 48'd0, 46'd0, 23'd0);
      tbl[4]  = mkVec(1, 24'h7FFFFF,  0, 1, 46'd0,  0, 48'd0, 46'd0, 23'd0);
      tbl[5]  = mkVec(1, 24'h7FFFFF,  0, 1, 46'h3FFFFF000001, 1, 48'd50, 46'd12, 23'd5);
      tbl[6]  = mkVec(1, 24'h7FFFFF,  0, 1, 46'h3FFFFF000001, 0, 48'd50, 46'd12, 23'd5);
      tbl[7]  = mkVec(1, 24'h7FFFFF,  0, 1, 46'h3FFFFF000001, 0, 48'd50, 46'd12, 23'd5);
      tbl[8]  = mkVec(1, 24'h800000,  0, 1, 46'h3FFFFF000001, 0, 48'd50, 46'd12, 23'd5);
      tbl[9]  = mkVec(1, 24'h800000,  0, 1, 46'd0, 1, 48'hFFFFFC000004, 46'h3FFFFF000001, 23'h7FFFFF);
      tbl[10] = mkVec(1, 24'h800000,  0, 1, 46'd0, 0, 48'hFFFFFC000004, 46'h3FFFFF000001, 23'h7FFFFF);
      tbl[11] = mkVec(1, 24'h800000,  0, 1, 46'd0, 0, 48'hFFFFFC000004, 46'h3FFFFF000001, 23'h7FFFFF);
      tbl[12] = mkVec(0, 24'd0,       0, 1, 46'd0, 0, 48'hFFFFFC000004, 46'h3FFFFF000001, 23'h7FFFFF);
      tbl[13] = mkVec(0, 24'd0,       0, 0, 46'd0, 1, 48'd0, 46'd0, 23'd0);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rstSqValid", 64'(sq_valid), 64'd0);
      checkOutput("rstSqOut", 64'(sq_out), 64'd0);
      checkOutput("rstWinValid", 64'(win_valid), 64'd0);
      checkOutput("rstWinSum", 64'(win_sum), 64'd0);
      checkOutput("rstWinMean", 64'(win_mean), 64'd0);
      checkOutput("rstPeak", 64'(peak_out), 64'd0);

      // Table: basic window, full-scale window, negative-zero window, back to back
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         rst      = 1'b0;
         in_valid = tbl[i].v;
         in_data  = tbl[i].d;
         win_clr  = tbl[i].clr;
         @(posedge clk);
         #1;
         checkOutput($sformatf("v%0d_sqValid", i), 64'(sq_valid), 64'(tbl[i].expSqV));
         if (tbl[i].expSqV)
            checkOutput($sformatf("v%0d_sqOut", i), 64'(sq_out), 64'(tbl[i].expSq));
         checkOutput($sformatf("v%0d_winValid", i), 64'(win_valid), 64'(tbl[i].expWinV));
         checkOutput($sformatf("v%0d_winSum", i), 64'(win_sum), 64'(tbl[i].expSum));
         checkOutput($sformatf("v%0d_winMean", i), 64'(win_mean), 64'(tbl[i].expMean));
         checkOutput($sformatf("v%0d_peak", i), 64'(peak_out), 64'(peakExp(tbl[i].expPeak)));
      end
      idle(2);

      // Eight samples of 2 with a 3-cycle gap after sample 2
      pulseCount = 0; widePulses = 0;
      pulseExpSum = 48'd16; pulseExpMean = 46'd4; pulseExpPeak = 23'd2;
      applyStimulus(1'b1, 24'd2, 1'b0, 1'b0);
      applyStimulus(1'b1, 24'd2, 1'b0, 1'b0);
      idle(3);
      for (int k = 0; k < 6; k++) applyStimulus(1'b1, 24'd2, 1'b0, 1'b0);
      idle(5);
      checkOutput("gapPulses", 64'(pulseCount), 64'd2);
      checkOutput("gapWidePulses", 64'(widePulses), 64'd0);

      // Abort with win_clr; the sample arriving with the clear starts the new window
      pulseCount = 0; widePulses = 0;
      pulseExpSum = 48'd196; pulseExpMean = 46'd49; pulseExpPeak = 23'd7;
      applyStimulus(1'b1, 24'd1, 1'b0, 1'b0);
      applyStimulus(1'b1, 24'd1, 1'b0, 1'b0);
      applyStimulus(1'b1, 24'd7, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, 24'd7, 1'b0, 1'b0);
      idle(5);
      checkOutput("clrPulses", 64'(pulseCount), 64'd1);
      checkOutput("clrHoldSum", 64'(win_sum), 64'd196);

      // Reset mid-window clears outputs and restarts counting
      pulseCount = 0; widePulses = 0;
      pulseExpSum = 48'd4; pulseExpMean = 46'd1; pulseExpPeak = 23'd1;
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, 24'd1, 1'b0, 1'b0);
      applyStimulus(1'b0, 24'd0, 1'b0, 1'b1);
      checkOutput("midRstSqValid", 64'(sq_valid), 64'd0);
      checkOutput("midRstSqOut", 64'(sq_out), 64'd0);
      checkOutput("midRstWinValid", 64'(win_valid), 64'd0);
      checkOutput("midRstWinSum", 64'(win_sum), 64'd0);
      checkOutput("midRstWinMean", 64'(win_mean), 64'd0);
      checkOutput("midRstPeak", 64'(peak_out), 64'd0);
      for (int k = 0; k < 4; k++) applyStimulus(1'b1, 24'd1, 1'b0, 1'b0);
      idle(5);
      checkOutput("rstPulses", 64'(pulseCount), 64'd1);
      checkOutput("rstFinalSum", 64'(win_sum), 64'd4);
      checkOutput("rstFinalMean", 64'(win_mean), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
